// File: rtl/control_mascara_secuencial.sv
// control_mascara_secuencial: register-programmed fetch of an N x N mask from coefficient
// memory, delivered one coefficient at a time over a valid/ready handshake.
module control_mascara_secuencial #(
    parameter int BITS_BUS_DATOS     = 21,
    parameter int BITS_BUS_DIRECCION = 11,
    parameter int BITS_DIRECCION_MEM = 10,
    parameter int BITS_MASCARA       = 3,
    parameter int BITS_COEFICIENTE   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BITS_BUS_DIRECCION-1:0] direccion_registros,
    input  logic [BITS_BUS_DATOS-1:0]     datos_registros,
    input  logic                          habilitacion_registros,
    output logic                          leer_mem,
    output logic [BITS_DIRECCION_MEM-1:0] direccion_mem,
    input  logic [BITS_COEFICIENTE-1:0]   datos_mem,
    output logic [BITS_COEFICIENTE-1:0]   coef_datos,
    output logic                          coef_valido,
    output logic                          coef_ultimo,
    input  logic                          coef_listo,
    output logic                          ocupado,
    output logic                          error_config
);
    typedef enum logic [1:0] {INACTIVO, LECTURA, ESPERA_DATO, ENTREGA} estado_t;
    localparam int BI = 2 * BITS_MASCARA;

    estado_t                       estado_q, estado_d;
    logic [BI-1:0]                 indice_q, indice_d;
    logic [BITS_MASCARA-1:0]       tamano_q, tamano_d;
    logic [BITS_DIRECCION_MEM-1:0] base_q, base_d, dir_q, dir_d;
    logic                          modo_auto_q, modo_auto_d, error_q, error_d;
    logic [BITS_COEFICIENTE-1:0]   coef_q, coef_d;
    logic                          valido_q, valido_d, ultimo_q, ultimo_d;

    logic                          wr_tam, wr_base, wr_ctrl, wr_clr, tam_ok;
    logic                          arranque, abortar, arrancar;
    logic [BITS_MASCARA-1:0]       tam_nuevo;
    logic [BI-1:0]                 tam_ext, ultimo_idx;
    logic [BITS_DIRECCION_MEM-1:0] dir_actual;
    logic                          unused_bits;

    assign wr_tam      = habilitacion_registros && direccion_registros[1:0] == 2'd0;
    assign wr_base     = habilitacion_registros && direccion_registros[1:0] == 2'd1;
    assign wr_ctrl     = habilitacion_registros && direccion_registros[1:0] == 2'd2;
    assign wr_clr      = habilitacion_registros && direccion_registros[1:0] == 2'd3 && datos_registros[0];
    assign tam_nuevo   = datos_registros[BITS_MASCARA-1:0];
    assign tam_ok      = tam_nuevo[0];
    assign arranque    = wr_ctrl && datos_registros[0];
    assign abortar     = wr_ctrl && datos_registros[2];
    assign arrancar    = arranque || (wr_base && modo_auto_q);
    assign tam_ext     = BI'(tamano_q);
    assign ultimo_idx  = tam_ext * tam_ext - BI'(1);
    assign dir_actual  = base_q + BITS_DIRECCION_MEM'(indice_q);
    assign unused_bits = &{direccion_registros[BITS_BUS_DIRECCION-1:2],
                           datos_registros[BITS_BUS_DATOS-1:BITS_DIRECCION_MEM]};

    assign ocupado       = estado_q != INACTIVO;
    assign leer_mem      = estado_q == LECTURA;
    assign direccion_mem = leer_mem ? dir_actual : dir_q;
    assign coef_datos    = coef_q;
    assign coef_valido   = valido_q;
    assign coef_ultimo   = ultimo_q;
    assign error_config  = error_q;

    always_comb begin
        tamano_d    = (wr_tam && tam_ok && !ocupado) ? tam_nuevo : tamano_q;
        base_d      = (wr_base && !ocupado) ? datos_registros[BITS_DIRECCION_MEM-1:0] : base_q;
        modo_auto_d = wr_ctrl ? datos_registros[1] : modo_auto_q;
        // a new error always wins over a simultaneous clear
        error_d     = (error_q && !wr_clr) || (wr_tam && (ocupado || !tam_ok)) || (wr_base && ocupado);
        dir_d       = leer_mem ? dir_actual : dir_q;
        estado_d    = estado_q;
        indice_d    = indice_q;
        coef_d      = coef_q;
        valido_d    = valido_q;
        ultimo_d    = ultimo_q;
        case (estado_q)
            INACTIVO: begin
                estado_d = arrancar ? LECTURA : INACTIVO;
                indice_d = '0;
            end
            LECTURA: estado_d = ESPERA_DATO;
            ESPERA_DATO: begin
                coef_d   = datos_mem;
                valido_d = 1'b1;
                ultimo_d = indice_q == ultimo_idx;
                estado_d = ENTREGA;
            end
            ENTREGA: if (coef_listo) begin
                valido_d = 1'b0;
                ultimo_d = 1'b0;
                estado_d = ultimo_q ? INACTIVO : LECTURA;
                indice_d = ultimo_q ? '0 : indice_q + BI'(1);
            end
        endcase
        if (abortar) begin
            estado_d = INACTIVO;
            indice_d = '0;
            valido_d = 1'b0;
            ultimo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= INACTIVO;
            indice_q    <= '0;
            tamano_q    <= BITS_MASCARA'(3);
            base_q      <= '0;
            modo_auto_q <= 1'b0;
            error_q     <= 1'b0;
            dir_q       <= '0;
            coef_q      <= '0;
            valido_q    <= 1'b0;
            ultimo_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            tamano_q    <= tamano_d;
            base_q      <= base_d;
            modo_auto_q <= modo_auto_d;
            error_q     <= error_d;
            dir_q       <= dir_d;
            coef_q      <= coef_d;
            valido_q    <= valido_d;
            ultimo_q    <= ultimo_d;
        end
    end
endmodule

// File: tb/tb_control_mascara_secuencial.sv
// tb_control_mascara_secuencial: scoreboard bench; expected read addresses and coefficients
// are queued when a fetch is launched and checked as the DUT issues reads and transfers.
module tb_control_mascara_secuencial;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] direccion_registros;
    logic [20:0] datos_registros;
    logic        habilitacion_registros;
    logic        leer_mem;
    logic [9:0]  direccion_mem;
    logic [15:0] datos_mem;
    logic [15:0] coef_datos;
    logic        coef_valido, coef_ultimo, coef_listo, ocupado, error_config;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0]  q_dir[$];
    logic [16:0] q_coef[$];

    control_mascara_secuencial dut (
        .clk(clk), .reset(reset),
        .direccion_registros(direccion_registros), .datos_registros(datos_registros),
        .habilitacion_registros(habilitacion_registros),
        .leer_mem(leer_mem), .direccion_mem(direccion_mem), .datos_mem(datos_mem),
        .coef_datos(coef_datos), .coef_valido(coef_valido), .coef_ultimo(coef_ultimo),
        .coef_listo(coef_listo), .ocupado(ocupado), .error_config(error_config)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [9:0] a);
        return {a[5:0], a} ^ 16'h5A3C;
    endfunction

    // memory answers exactly one cycle after a read strobe, garbage otherwise
    always @(posedge clk) datos_mem <= leer_mem ? mem_f(direccion_mem) : 16'hDEAD;

    always @(negedge clk) if (reset) begin
        if (leer_mem) begin
            n_cmp++;
            if (q_dir.size() == 0) begin
                n_bad++;
                $display("FAIL read_addr: read issued at %h, no read required", direccion_mem);
            end else begin
                logic [9:0] e;
                e = q_dir.pop_front();
                if (direccion_mem !== e) begin
                    n_bad++;
                    $display("FAIL read_addr: got %h, required %h", direccion_mem, e);
                end
            end
        end
        if (coef_valido && coef_listo) begin
            n_cmp++;
            if (q_coef.size() == 0) begin
                n_bad++;
                $display("FAIL coef_xfer: transfer of %h, no transfer required", coef_datos);
            end else begin
                logic [16:0] e;
                e = q_coef.pop_front();
                if ({coef_ultimo, coef_datos} !== e) begin
                    n_bad++;
                    $display("FAIL coef_xfer: got last=%b data=%h, required last=%b data=%h",
                             coef_ultimo, coef_datos, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [20:0] d);
        direccion_registros = {9'h0, a};
        datos_registros = d;
        habilitacion_registros = 1'b1;
        @(posedge clk);
        #1;
        habilitacion_registros = 1'b0;
    endtask

    task automatic push_fetch(input logic [9:0] base, input int n);
        for (int i = 0; i < n * n; i++) begin
            logic [9:0] a;
            a = base + 10'(i);
            q_dir.push_back(a);
            q_coef.push_back({i == n * n - 1, mem_f(a)});
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i = 0;
        while ((ocupado || q_dir.size() != 0 || q_coef.size() != 0) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        n_cmp++;
        if (ocupado !== 1'b0 || q_dir.size() != 0 || q_coef.size() != 0) begin
            n_bad++;
            $display("FAIL %s_idle: ocupado=%b reads_left=%0d coefs_left=%0d, required 0/0/0",
                     nm, ocupado, q_dir.size(), q_coef.size());
        end
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int i = 0;
        while (coef_valido !== 1'b1 && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        n_cmp++;
        if (coef_valido !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid: coef_valido=%b, required 1", nm, coef_valido);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({leer_mem, direccion_mem, coef_datos, coef_valido, coef_ultimo, ocupado, error_config} !== 31'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got leer=%b dir=%h coef=%h v=%b u=%b oc=%b err=%b, required all 0",
                     leer_mem, direccion_mem, coef_datos, coef_valido, coef_ultimo, ocupado, error_config);
        end
    endtask

    task automatic test_basic();
        coef_listo = 1'b1;
        wr(2'd1, 21'h010);
        push_fetch(10'h010, 3);
        wr(2'd2, 21'h1);
        n_cmp++;
        if (leer_mem !== 1'b1 || ocupado !== 1'b1 || direccion_mem !== 10'h010) begin
            n_bad++;
            $display("FAIL basic_first_read: leer=%b oc=%b dir=%h, required 1/1/010", leer_mem, ocupado, direccion_mem);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (leer_mem !== 1'b0 || coef_valido !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_wait: leer=%b v=%b, required 0/0", leer_mem, coef_valido);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (coef_valido !== 1'b1 || coef_datos !== mem_f(10'h010)) begin
            n_bad++;
            $display("FAIL basic_latency: v=%b data=%h, required 1/%h", coef_valido, coef_datos, mem_f(10'h010));
        end
        wait_idle(100, "basic");
        n_cmp++;
        if (error_config !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_err: got %b, required 0", error_config);
        end
    endtask

    task automatic test_wrap();
        wr(2'd0, 21'h5);
        wr(2'd1, 21'h3FC);
        push_fetch(10'h3FC, 5);
        wr(2'd2, 21'h1);
        wait_idle(200, "wrap");
        n_cmp++;
        if (error_config !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_err: got %b, required 0", error_config);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        wr(2'd0, 21'h3);
        wr(2'd1, 21'h040);
        coef_listo = 1'b0;
        push_fetch(10'h040, 3);
        wr(2'd2, 21'h1);
        wait_valid(10, "stall");
        held = coef_datos;
        n_cmp++;
        if (held !== mem_f(10'h040)) begin
            n_bad++;
            $display("FAIL stall_first: got %h, required %h", held, mem_f(10'h040));
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (coef_valido !== 1'b1 || coef_datos !== held || leer_mem !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold: v=%b data=%h leer=%b, required 1/%h/0", coef_valido, coef_datos, leer_mem, held);
            end
        end
        coef_listo = 1'b1;
        wait_idle(100, "stall");
    endtask

    task automatic test_error();
        wr(2'd0, 21'h4);
        n_cmp++;
        if (error_config !== 1'b1) begin
            n_bad++;
            $display("FAIL err_even: got %b, required 1", error_config);
        end
        wr(2'd3, 21'h1);
        n_cmp++;
        if (error_config !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got %b, required 0", error_config);
        end
        wr(2'd0, 21'h0);
        n_cmp++;
        if (error_config !== 1'b1) begin
            n_bad++;
            $display("FAIL err_zero: got %b, required 1", error_config);
        end
        wr(2'd3, 21'h1);
        wr(2'd1, 21'h080);
        push_fetch(10'h080, 3);
        wr(2'd2, 21'h1);
        wait_idle(100, "err_size");
    endtask

    task automatic test_abort();
        coef_listo = 1'b0;
        wr(2'd2, 21'h2);
        for (int i = 0; i < 4; i++) q_dir.push_back(10'h100 + 10'(i));
        for (int i = 0; i < 3; i++) q_coef.push_back({1'b0, mem_f(10'h100 + 10'(i))});
        wr(2'd1, 21'h100);
        for (int k = 0; k < 3; k++) begin
            wait_valid(10, "abort_pre");
            coef_listo = 1'b1;
            @(posedge clk);
            #1;
            coef_listo = 1'b0;
        end
        wait_valid(10, "abort_4th");
        n_cmp++;
        if (coef_datos !== mem_f(10'h103) || coef_ultimo !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_4th_data: data=%h u=%b, required %h/0", coef_datos, coef_ultimo, mem_f(10'h103));
        end
        wr(2'd2, 21'h3);
        n_cmp++;
        if (error_config !== 1'b0 || coef_valido !== 1'b1 || ocupado !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_start: err=%b v=%b oc=%b, required 0/1/1", error_config, coef_valido, ocupado);
        end
        wr(2'd1, 21'h200);
        n_cmp++;
        if (error_config !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_base_err: got %b, required 1", error_config);
        end
        wr(2'd2, 21'h7);
        n_cmp++;
        if (coef_valido !== 1'b0 || coef_ultimo !== 1'b0 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: v=%b u=%b oc=%b, required 0/0/0", coef_valido, coef_ultimo, ocupado);
        end
        repeat (6) @(posedge clk);
        #1;
        wait_idle(1, "abort");
        wr(2'd3, 21'h1);
        wr(2'd2, 21'h0);
    endtask

    task automatic test_reset_mid();
        coef_listo = 1'b0;
        wr(2'd0, 21'h5);
        wr(2'd1, 21'h020);
        q_dir.push_back(10'h020);
        wr(2'd2, 21'h1);
        wait_valid(10, "rst_mid");
        #2;
        reset = 1'b0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        coef_listo = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (ocupado !== 1'b0 || q_dir.size() != 0) begin
            n_bad++;
            $display("FAIL rst_mid_idle: oc=%b reads_left=%0d, required 0/0", ocupado, q_dir.size());
        end
        push_fetch(10'h000, 3);
        wr(2'd2, 21'h1);
        wait_idle(100, "rst_mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        direccion_registros = '0;
        datos_registros = '0;
        habilitacion_registros = 1'b0;
        coef_listo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_wrap();
        test_backpressure();
        test_error();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
